// File: rtl/gf2m_pkg.sv
// Shared constants and types for the GF(2^131) reduction path.
package gf2m_pkg;

  localparam int GF_N = 131;
  localparam logic [GF_N-1:0] GF_POLY_LOW = 131'h2007;  // x^13 + x^2 + x + 1
  localparam int GF_PROD_W = 2 * GF_N - 1;
  localparam int GF_NFOLD = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gf2m_fold_step.sv
// One combinational folding step: the high part H = W[2N-2:N] is folded back
// onto the low part using x^N == POLY_LOW (mod f). Because POLY_LOW is sparse,
// the carry-less product H * POLY_LOW is just the XOR of shifted copies of H.
module gf2m_fold_step #(
  parameter int N = 131,
  parameter logic [N-1:0] POLY_LOW = 131'h2007
) (
  input  logic [2*N-2:0] w_in,
  output logic [2*N-2:0] w_out
);

  localparam int W = 2 * N - 1;

  logic [W-1:0] h_ext;
  logic [W-1:0] low_ext;

  // Zero-extended high and low halves of the working value.
  always_comb begin
    h_ext   = '0;
    low_ext = '0;
    h_ext[N-2:0]   = w_in[W-1:N];
    low_ext[N-1:0] = w_in[N-1:0];
  end

  // XOR in one shifted copy of H per set bit of POLY_LOW; for legal
  // parameters no shifted bit falls off the top of the W-bit word.
  always_comb begin
    w_out = low_ext;
    for (int k = 0; k < N; k++) begin
      if (POLY_LOW[k]) begin
        w_out = w_out ^ (h_ext << k);
      end
    end
  end

endmodule

// File: rtl/gf2m_fold_reducer.sv
// Sequential reducer: folds a 261-bit GF(2)[x] product modulo
// x^131 + x^13 + x^2 + x + 1 over NFOLD cycles, one operation in flight.
module gf2m_fold_reducer
  import gf2m_pkg::*;
#(
  parameter int N = GF_N,
  parameter logic [N-1:0] POLY_LOW = GF_POLY_LOW,
  parameter int NFOLD = GF_NFOLD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-2:0] in_prod,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_res,
  output logic           busy
);

  localparam int W  = 2 * N - 1;
  localparam int CW = $clog2(NFOLD + 1);
  localparam logic [CW-1:0] LAST_FOLD = CW'(NFOLD - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  w_q, w_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  w_fold;

  gf2m_fold_step #(
    .N        (N),
    .POLY_LOW (POLY_LOW)
  ) u_fold_step (
    .w_in  (w_q),
    .w_out (w_fold)
  );

  // Next-state logic: accept in IDLE, fold NFOLD times, present in DONE.
  // DONE accepts a new product in the same cycle its result is taken.
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_d     = in_prod;
          cnt_d   = '0;
          state_d = FOLD;
        end
      end
      FOLD: begin
        w_d   = w_fold;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_FOLD) begin
          state_d = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_d     = in_prod;
            cnt_d   = '0;
            state_d = FOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, work register and fold counter; reset discards any in-flight work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
    end
  end

  // The low half of the work register is the result once folding is done.
  assign out_res   = w_q[N-1:0];
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gf2m_fold_reducer.sv
// Directed bench for gf2m_fold_reducer with hand-reduced expected values.
module tb_gf2m_fold_reducer;

  localparam int N = 131;
  localparam int W = 2 * N - 1;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_prod;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_res;
  logic         busy;

  int vectors;
  int miscompares;

  gf2m_fold_reducer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, two fold cycles, result taken immediately.
  task automatic run_vec(input string tag, input logic [W-1:0] prod, input logic [N-1:0] exp);
    in_prod   = prod;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk_bit({tag, "_in_ready"}, in_ready, 1'b1);
    tick();                         // accept edge
    in_valid = 1'b0;
    in_prod  = ~prod;               // must not affect the result
    chk_bit({tag, "_busy"}, busy, 1'b1);
    chk_bit({tag, "_nv1"}, out_valid, 1'b0);
    tick();
    chk_bit({tag, "_nv2"}, out_valid, 1'b0);
    tick();
    chk_bit({tag, "_valid"}, out_valid, 1'b1);
    chk_res({tag, "_res"}, out_res, exp);
    tick();                         // result taken
    chk_bit({tag, "_idle_ready"}, in_ready, 1'b1);
    chk_bit({tag, "_idle_nv"}, out_valid, 1'b0);
    $display("vec %s prod=%h res=%h exp=%h", tag, prod, out_res, exp);
  endtask

  logic [W-1:0] p, p1, p2;
  logic [N-1:0] e, e1, e2;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_prod     = '0;

    #2;
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_res("rst_out_res", out_res, '0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1 is already reduced.
    p = '0; p[0] = 1'b1;
    e = '0; e[0] = 1'b1;
    run_vec("one", p, e);

    // x^131 -> x^13 + x^2 + x + 1
    p = '0; p[131] = 1'b1;
    e = 131'h2007;
    run_vec("x131", p, e);

    // x^260 -> {130,129,24,12,11,2,1,0}; second fold is needed here.
    p = '0; p[260] = 1'b1;
    e = '0;
    e[130] = 1'b1; e[129] = 1'b1; e[24] = 1'b1; e[12] = 1'b1;
    e[11] = 1'b1; e[2] = 1'b1; e[1] = 1'b1; e[0] = 1'b1;
    run_vec("x260", p, e);

    // x^250 -> x^121+x^120+x^119 then x^132 folds to x^14+x^3+x^2+x
    p = '0; p[250] = 1'b1;
    e = '0;
    e[121] = 1'b1; e[120] = 1'b1; e[119] = 1'b1;
    e[14] = 1'b1; e[3] = 1'b1; e[2] = 1'b1; e[1] = 1'b1;
    run_vec("x250", p, e);

    // x^140 + x^5 -> x^22 + x^11 + x^10 + x^9 + x^5
    p = '0; p[140] = 1'b1; p[5] = 1'b1;
    e = '0;
    e[22] = 1'b1; e[11] = 1'b1; e[10] = 1'b1; e[9] = 1'b1; e[5] = 1'b1;
    run_vec("x140_x5", p, e);

    // All low bits set, no high bits: passes through unchanged.
    p = '0; p[N-1:0] = '1;
    e = '1;
    run_vec("low_ones", p, e);

    // Stall: result must hold while out_ready is low; in_valid ignored in FOLD.
    p = '0; p[200] = 1'b1;
    e = '0; e[82] = 1'b1; e[71] = 1'b1; e[70] = 1'b1; e[69] = 1'b1;
    in_prod   = p;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();                         // accept
    in_prod = '1;                   // held valid during FOLD must be ignored
    chk_bit("stall_fold_in_ready", in_ready, 1'b0);
    tick();
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_bit("stall_valid", out_valid, 1'b1);
      chk_res("stall_res", out_res, e);
      chk_bit("stall_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk_bit("stall_release_ready", in_ready, 1'b1);
    tick();
    chk_bit("stall_done_nv", out_valid, 1'b0);
    chk_bit("stall_done_idle", busy, 1'b0);
    $display("stall prod=x^200 res=%h exp=%h", e, e);

    // Back-to-back: accept every 3 cycles, results in order.
    p = '0;  p[131] = 1'b1;  e = 131'h2007;
    p1 = '0; p1[140] = 1'b1; e1 = '0; e1[22] = 1'b1; e1[11] = 1'b1; e1[10] = 1'b1; e1[9] = 1'b1;
    p2 = '0; p2[3] = 1'b1;   e2 = '0; e2[3] = 1'b1;
    in_prod   = p;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();                         // accept p
    in_prod = p1;
    chk_bit("b2b_f0_ready", in_ready, 1'b0);
    tick();
    chk_bit("b2b_f1_nv", out_valid, 1'b0);
    tick();
    chk_bit("b2b_r0_valid", out_valid, 1'b1);
    chk_res("b2b_r0_res", out_res, e);
    chk_bit("b2b_r0_ready", in_ready, 1'b1);
    $display("b2b res0=%h exp=%h", out_res, e);
    tick();                         // accept p1
    in_prod = p2;
    chk_bit("b2b_a1_busy", busy, 1'b1);
    chk_bit("b2b_a1_nv", out_valid, 1'b0);
    tick();
    tick();
    chk_bit("b2b_r1_valid", out_valid, 1'b1);
    chk_res("b2b_r1_res", out_res, e1);
    $display("b2b res1=%h exp=%h", out_res, e1);
    tick();                         // accept p2
    in_valid = 1'b0;
    in_prod  = '0;
    tick();
    tick();
    chk_bit("b2b_r2_valid", out_valid, 1'b1);
    chk_res("b2b_r2_res", out_res, e2);
    $display("b2b res2=%h exp=%h", out_res, e2);
    tick();
    chk_bit("b2b_end_idle", busy, 1'b0);

    // Reset during FOLD discards the product without an out_valid pulse.
    p = '0; p[200] = 1'b1;
    in_prod   = p;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();                         // accept
    in_valid = 1'b0;
    chk_bit("rstmid_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_bit("rstmid_nv", out_valid, 1'b0);
    chk_bit("rstmid_ready", in_ready, 1'b1);
    chk_bit("rstmid_busy0", busy, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_bit("rstmid_after_nv", out_valid, 1'b0);
      tick();
    end
    $display("rstmid aborted prod=x^200 out_valid=%b", out_valid);
    p = '0; p[131] = 1'b1;
    run_vec("post_rst_x131", p, 131'h2007);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
